// File: rtl/queue_button_conditioner.sv
// Two-channel push-button conditioner: 2-flop sync, debounce, entry/exit interlock, pulses.
// Optional stuck-press detection is built when QBC_STUCK_DETECT_EN is defined.
//
// state        | meaning
// IDLE         | button released and accepted as released
// ARM_PRESS    | s2 high, counting toward an accepted press
// PRESSED      | press accepted, level high
// ARM_RELEASE  | s2 low while pressed, counting toward an accepted release
// STUCK        | (QBC_STUCK_DETECT_EN) held too long, waiting for a debounced release
module queue_button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned CNT_W           = 17,
   parameter int unsigned STUCK_CYCLES    = 50000000,
   parameter int unsigned HOLD_W          = 26
) (
   input  logic clk_in,
   input  logic reset,
   input  logic btn_in_raw,
   input  logic btn_out_raw,
   output logic in_level,
   output logic out_level,
   output logic in_pulse,
   output logic out_pulse,
   output logic busy,
   output logic in_stuck,
   output logic out_stuck
);

   typedef enum logic [2:0] {
      IDLE,
      ARM_PRESS,
      PRESSED,
      ARM_RELEASE
`ifdef QBC_STUCK_DETECT_EN
      , STUCK
`endif
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channel index 0 is entry, 1 is exit.
   logic [1:0]       s1_q, s1_d, s2_q, s2_d;
   state_t           state_q [2];
   state_t           state_d [2];
   logic [CNT_W-1:0] cnt_q   [2];
   logic [CNT_W-1:0] cnt_d   [2];
   logic [1:0]       level_q, level_d;
   logic [1:0]       pulse_q, pulse_d;
   logic             busy_q, busy_d;

   logic [1:0]       hold_ch;
   logic [1:0]       term;
   logic [1:0]       accept;

`ifdef QBC_STUCK_DETECT_EN
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STUCK_CYCLES - 1);
   logic [HOLD_W-1:0] hold_q [2];
   logic [HOLD_W-1:0] hold_d [2];
   logic [1:0]        rel_q, rel_d;
   logic [1:0]        stuck_q, stuck_d;
`endif

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         level_q <= '0;
         pulse_q <= '0;
         busy_q  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
`ifdef QBC_STUCK_DETECT_EN
            hold_q[i]  <= '0;
`endif
         end
`ifdef QBC_STUCK_DETECT_EN
         rel_q   <= '0;
         stuck_q <= '0;
`endif
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
`ifdef QBC_STUCK_DETECT_EN
            hold_q[i]  <= hold_d[i];
`endif
         end
`ifdef QBC_STUCK_DETECT_EN
         rel_q   <= rel_d;
         stuck_q <= stuck_d;
`endif
      end
   end

   // Arbitration: a channel holding the pressed level blocks the other; entry wins a tie.
   always_comb begin
      s1_d = {btn_out_raw, btn_in_raw};
      s2_d = s1_q;
      for (int i = 0; i < 2; i++) begin
         hold_ch[i] = (state_q[i] == PRESSED) || (state_q[i] == ARM_RELEASE);
         term[i]    = (state_q[i] == ARM_PRESS) && s2_q[i] && (cnt_q[i] == DB_LAST);
      end
      accept[0] = term[0] && !hold_ch[1];
      accept[1] = term[1] && !hold_ch[0] && !accept[0];
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
`ifdef QBC_STUCK_DETECT_EN
         hold_d[i]  = hold_q[i];
         rel_d[i]   = rel_q[i];
`endif
         case (state_q[i])
            IDLE: begin
               if (s2_q[i] && !hold_ch[i ^ 1]) begin
                  state_d[i] = ARM_PRESS;
                  cnt_d[i]   = '0;
               end
            end
            ARM_PRESS: begin
               if (!s2_q[i]) begin
                  state_d[i] = IDLE;
               end else if (cnt_q[i] == DB_LAST) begin
                  // A press losing arbitration drops back and re-arms once unblocked.
                  state_d[i] = accept[i] ? PRESSED : IDLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            PRESSED: begin
               if (!s2_q[i]) begin
                  state_d[i] = ARM_RELEASE;
                  cnt_d[i]   = '0;
               end
            end
            ARM_RELEASE: begin
               if (s2_q[i]) begin
                  state_d[i] = PRESSED;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i] = IDLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
`ifdef QBC_STUCK_DETECT_EN
            // rel marks that a low s2 has been seen, so the release count lines up with ARM_RELEASE.
            STUCK: begin
               if (s2_q[i]) begin
                  cnt_d[i] = '0;
                  rel_d[i] = 1'b0;
               end else if (!rel_q[i]) begin
                  cnt_d[i] = '0;
                  rel_d[i] = 1'b1;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i] = IDLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
`endif
            default: state_d[i] = IDLE;
         endcase
`ifdef QBC_STUCK_DETECT_EN
         // Hold time spans bounces inside a press; only a fresh acceptance clears it.
         if (accept[i]) begin
            hold_d[i] = '0;
         end else if (hold_ch[i]) begin
            if (hold_q[i] == HOLD_LAST) begin
               state_d[i] = STUCK;
               cnt_d[i]   = '0;
               rel_d[i]   = 1'b0;
            end else begin
               hold_d[i] = hold_q[i] + 1'b1;
            end
         end
`endif
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == ARM_RELEASE);
         pulse_d[i] = accept[i];
`ifdef QBC_STUCK_DETECT_EN
         stuck_d[i] = (state_d[i] == STUCK);
`endif
      end
      busy_d = (state_q[0] != IDLE) || (state_q[1] != IDLE);
   end

   assign in_level  = level_q[0];
   assign out_level = level_q[1];
   assign in_pulse  = pulse_q[0];
   assign out_pulse = pulse_q[1];
   assign busy      = busy_q;
`ifdef QBC_STUCK_DETECT_EN
   assign in_stuck  = stuck_q[0];
   assign out_stuck = stuck_q[1];
`else
   assign in_stuck  = 1'b0;
   assign out_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_queue_button_conditioner.sv
// Directed bench for queue_button_conditioner with DEBOUNCE_CYCLES=8, STUCK_CYCLES=64.
// Edge index e counts posedges after inputs change; outputs sampled 1 time unit after each edge.
module tb_queue_button_conditioner;

   logic clk_in = 1'b0;
   logic reset = 1'b1;
   logic btn_in_raw = 1'b0;
   logic btn_out_raw = 1'b0;
   logic in_level, out_level, in_pulse, out_pulse, busy, in_stuck, out_stuck;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses;

   always #5 clk_in = ~clk_in;

   queue_button_conditioner #(
      .DEBOUNCE_CYCLES(8),
      .CNT_W(17),
      .STUCK_CYCLES(64),
      .HOLD_W(26)
   ) dut (
      .clk_in(clk_in),
      .reset(reset),
      .btn_in_raw(btn_in_raw),
      .btn_out_raw(btn_out_raw),
      .in_level(in_level),
      .out_level(out_level),
      .in_pulse(in_pulse),
      .out_pulse(out_pulse),
      .busy(busy),
      .in_stuck(in_stuck),
      .out_stuck(out_stuck)
   );

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_level"}, in_level, 1'b0);
      chk({tag, "_out_level"}, out_level, 1'b0);
      chk({tag, "_in_pulse"}, in_pulse, 1'b0);
      chk({tag, "_out_pulse"}, out_pulse, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_in_stuck"}, in_stuck, 1'b0);
      chk({tag, "_out_stuck"}, out_stuck, 1'b0);
   endtask

   initial begin
      repeat (3) tick();
      chk_all_zero("rst");

      // Entry press from edge 0: accepted on edge 10, busy from edge 3.
      reset = 1'b0;
      btn_in_raw = 1'b1;
      for (int e = 0; e < 13; e++) begin
         tick();
         chk($sformatf("t1_in_level_e%0d", e), in_level, e >= 10);
         chk($sformatf("t1_in_pulse_e%0d", e), in_pulse, e == 10);
         chk($sformatf("t1_busy_e%0d", e), busy, e >= 3);
         chk($sformatf("t1_out_level_e%0d", e), out_level, 1'b0);
         chk($sformatf("t1_out_pulse_e%0d", e), out_pulse, 1'b0);
      end

      // Release: same latency.
      btn_in_raw = 1'b0;
      for (int e = 0; e < 13; e++) begin
         tick();
         chk($sformatf("t1r_in_level_e%0d", e), in_level, e < 10);
         chk($sformatf("t1r_in_pulse_e%0d", e), in_pulse, 1'b0);
      end
      repeat (3) tick();
      chk("t1r_busy_idle", busy, 1'b0);

      // Bounce: 1 x5, 0 x2, then stable 1 from edge b.
      pulses = 0;
      btn_in_raw = 1'b1;
      for (int e = 0; e < 5; e++) begin
         tick();
         pulses += int'(in_pulse);
         chk($sformatf("t2_bounce_hi_level_e%0d", e), in_level, 1'b0);
      end
      btn_in_raw = 1'b0;
      for (int e = 0; e < 2; e++) begin
         tick();
         pulses += int'(in_pulse);
         chk($sformatf("t2_bounce_lo_level_e%0d", e), in_level, 1'b0);
      end
      btn_in_raw = 1'b1;
      for (int e = 0; e < 14; e++) begin
         tick();
         pulses += int'(in_pulse);
         chk($sformatf("t2_in_pulse_e%0d", e), in_pulse, e == 10);
         chk($sformatf("t2_in_level_e%0d", e), in_level, e >= 10);
      end
      chk("t2_one_pulse", pulses == 1, 1'b1);

      // Interlock: exit held while entry is pressed.
      btn_out_raw = 1'b1;
      for (int e = 0; e < 20; e++) begin
         tick();
         chk($sformatf("t3_blk_out_level_e%0d", e), out_level, 1'b0);
         chk($sformatf("t3_blk_out_pulse_e%0d", e), out_pulse, 1'b0);
      end
      btn_in_raw = 1'b0;
      for (int e = 0; e < 26; e++) begin
         tick();
         chk($sformatf("t3_in_level_e%0d", e), in_level, e < 10);
         chk($sformatf("t3_in_pulse_e%0d", e), in_pulse, 1'b0);
         chk($sformatf("t3_out_pulse_e%0d", e), out_pulse, e == 19);
         chk($sformatf("t3_out_level_e%0d", e), out_level, e >= 19);
      end
      btn_out_raw = 1'b0;
      repeat (15) tick();
      chk("t3_out_level_released", out_level, 1'b0);
      chk("t3_busy_idle", busy, 1'b0);

      // Both buttons rise on the same edge: entry wins.
      btn_in_raw = 1'b1;
      btn_out_raw = 1'b1;
      for (int e = 0; e < 15; e++) begin
         tick();
         chk($sformatf("t4_in_pulse_e%0d", e), in_pulse, e == 10);
         chk($sformatf("t4_in_level_e%0d", e), in_level, e >= 10);
         chk($sformatf("t4_out_pulse_e%0d", e), out_pulse, 1'b0);
         chk($sformatf("t4_out_level_e%0d", e), out_level, 1'b0);
      end

      // Asynchronous reset while pressed, entry still held afterwards.
      chk("t5_pre_in_level", in_level, 1'b1);
      reset = 1'b1;
      btn_out_raw = 1'b0;
      #1;
      chk_all_zero("t5_async");
      tick();
      reset = 1'b0;
      for (int e = 0; e < 100; e++) begin
         tick();
         chk($sformatf("t5_in_pulse_e%0d", e), in_pulse, e == 10);
         chk($sformatf("t5_busy_e%0d", e), busy, e >= 3);
`ifdef QBC_STUCK_DETECT_EN
         chk($sformatf("t6_in_level_e%0d", e), in_level, (e >= 10) && (e < 74));
         chk($sformatf("t6_in_stuck_e%0d", e), in_stuck, e >= 74);
`else
         chk($sformatf("t6_in_level_e%0d", e), in_level, e >= 10);
         chk($sformatf("t6_in_stuck_e%0d", e), in_stuck, 1'b0);
`endif
         chk($sformatf("t6_out_stuck_e%0d", e), out_stuck, 1'b0);
      end

      // Release after the long hold.
      btn_in_raw = 1'b0;
      for (int e = 0; e < 13; e++) begin
         tick();
         chk($sformatf("t6r_in_pulse_e%0d", e), in_pulse, 1'b0);
`ifdef QBC_STUCK_DETECT_EN
         chk($sformatf("t6r_in_stuck_e%0d", e), in_stuck, e < 10);
         chk($sformatf("t6r_in_level_e%0d", e), in_level, 1'b0);
`else
         chk($sformatf("t6r_in_stuck_e%0d", e), in_stuck, 1'b0);
         chk($sformatf("t6r_in_level_e%0d", e), in_level, e < 10);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
